// File: rtl/inference_ctrl.sv
// rtl/inference_ctrl.sv - frame-level inference sequencer with ifmap BRAM read arbitration
// Optional watchdog on a hung accelerator: define INFER_CTRL_WDT_EN.
module inference_ctrl #(
   parameter int               ADDR_W     = 10,
   parameter int               DATA_W     = 8,
   parameter int               CLS_W      = 4,
   parameter logic [CLS_W-1:0] RESULT_RST = CLS_W'(4'hF),
   parameter int               TMO_CYC    = 1048575
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_abort,
   input  logic              bram_ready,
   input  logic              acc_read_en,
   input  logic [ADDR_W-1:0] acc_read_addr,
   output logic [DATA_W-1:0] acc_data,
   output logic              acc_enable,
   output logic              acc_soft_reset,
   input  logic [CLS_W-1:0]  acc_out,
   input  logic              acc_out_valid,
   input  logic              dbg_read_req,
   input  logic [ADDR_W-1:0] dbg_read_addr,
   output logic              dbg_read_grant,
   output logic              dbg_read_valid,
   output logic [DATA_W-1:0] dbg_read_data,
   output logic [ADDR_W-1:0] bram_read_addr,
   input  logic [DATA_W-1:0] bram_data,
   output logic [CLS_W-1:0]  result,
   output logic              result_valid,
   output logic              busy,
   output logic              timeout,
   output logic [7:0]        frame_count
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DONE, S_ABORT} state_t;

   state_t            state_q, state_d;
   logic              acc_enable_q;
   logic              dbg_valid_q;
   logic [DATA_W-1:0] dbg_data_q;
   logic [CLS_W-1:0]  result_q, result_d;
   logic              result_valid_q, result_valid_d;
   logic [7:0]        frame_count_q, frame_count_d;
   logic              wdt_hit;
   logic              take_timeout;
   logic              dbg_grant;

   // The accelerator always addresses the BRAM directly in RUN, its strobe is informational only.
   logic unused_acc_read_en;
   assign unused_acc_read_en = acc_read_en;

`ifdef INFER_CTRL_WDT_EN
   localparam logic [19:0] WdtLimit = 20'(TMO_CYC);

   logic [19:0] wdt_q, wdt_d;
   logic        timeout_q, timeout_d;

   assign wdt_hit = (state_q == S_RUN) && ((wdt_q + 20'd1) == WdtLimit);

   always_comb begin
      wdt_d     = wdt_q;
      timeout_d = timeout_q;
      if (state_d == S_ARM) begin
         wdt_d     = '0;
         timeout_d = 1'b0;
      end else if (state_q == S_RUN) begin
         wdt_d = wdt_q + 20'd1;
      end
      if (take_timeout) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wdt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdt_q     <= wdt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_tmo;
   assign unused_tmo = (TMO_CYC == 0);
   assign wdt_hit    = 1'b0;
   assign timeout    = 1'b0;
`endif

   // Abort outranks everything, including a result arriving in the same cycle.
   always_comb begin
      state_d        = state_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      frame_count_d  = frame_count_q;
      take_timeout   = 1'b0;
      if (frame_abort) begin
         state_d = S_ABORT;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bram_ready) state_d = S_ARM;
            end
            S_ARM: begin
               state_d = S_RUN;
            end
            S_RUN: begin
               if (acc_out_valid) begin
                  state_d        = S_DONE;
                  result_d       = acc_out;
                  result_valid_d = 1'b1;
                  frame_count_d  = frame_count_q + 8'd1;
               end else if (wdt_hit) begin
                  state_d      = S_DONE;
                  result_d     = RESULT_RST;
                  take_timeout = 1'b1;
               end
            end
            S_DONE: begin
               if (!bram_ready) state_d = S_IDLE;
            end
            S_ABORT: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      if ((state_d == S_ARM) || (state_d == S_ABORT)) begin
         result_valid_d = 1'b0;
      end
   end

   assign dbg_grant = (state_q != S_RUN) && dbg_read_req;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         acc_enable_q   <= 1'b0;
         dbg_valid_q    <= 1'b0;
         dbg_data_q     <= '0;
         result_q       <= RESULT_RST;
         result_valid_q <= 1'b0;
         frame_count_q  <= 8'd0;
      end else begin
         state_q        <= state_d;
         acc_enable_q   <= (state_d == S_RUN);
         dbg_valid_q    <= dbg_grant;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         frame_count_q  <= frame_count_d;
         if (dbg_valid_q) begin
            dbg_data_q <= bram_data;
         end
      end
   end

   // BRAM data lands one cycle after the granted address; present it then and hold it afterwards.
   assign dbg_read_data  = dbg_valid_q ? bram_data : dbg_data_q;
   assign dbg_read_valid = dbg_valid_q;
   assign dbg_read_grant = dbg_grant;
   assign bram_read_addr = (state_q == S_RUN) ? acc_read_addr : dbg_read_addr;
   assign acc_data       = bram_data;
   assign acc_enable     = acc_enable_q;
   assign acc_soft_reset = (state_q == S_ARM) || (state_q == S_ABORT);
   assign busy           = (state_q == S_ARM) || (state_q == S_RUN);
   assign result         = result_q;
   assign result_valid   = result_valid_q;
   assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_inference_ctrl.sv
// tb/tb_inference_ctrl.sv - self-checking bench for inference_ctrl
module tb_inference_ctrl;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int CLS_W  = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              frame_abort = 1'b0;
   logic              bram_ready = 1'b0;
   logic              acc_read_en = 1'b0;
   logic [ADDR_W-1:0] acc_read_addr = '0;
   logic [DATA_W-1:0] acc_data;
   logic              acc_enable;
   logic              acc_soft_reset;
   logic [CLS_W-1:0]  acc_out = '0;
   logic              acc_out_valid = 1'b0;
   logic              dbg_read_req = 1'b0;
   logic [ADDR_W-1:0] dbg_read_addr = '0;
   logic              dbg_read_grant;
   logic              dbg_read_valid;
   logic [DATA_W-1:0] dbg_read_data;
   logic [ADDR_W-1:0] bram_read_addr;
   logic [DATA_W-1:0] bram_data;
   logic [CLS_W-1:0]  result;
   logic              result_valid;
   logic              busy;
   logic              timeout;
   logic [7:0]        frame_count;

   logic [DATA_W-1:0] mem [1024];
   logic [DATA_W-1:0] sb_q [$];
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] cls;
      int         run_cyc;
      int         mode;      // 0 result, 1 abort, 2 abort together with result
      logic [9:0] dbg_addr;
      logic [3:0] exp_res;
      logic       exp_valid;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs [6];

   always #5 clock = ~clock;

   always @(posedge clock) bram_data <= mem[bram_read_addr];

   inference_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLS_W(CLS_W),
                    .RESULT_RST(4'hF), .TMO_CYC(100)) dut (
      .clock(clock), .reset(reset), .frame_abort(frame_abort), .bram_ready(bram_ready),
      .acc_read_en(acc_read_en), .acc_read_addr(acc_read_addr), .acc_data(acc_data),
      .acc_enable(acc_enable), .acc_soft_reset(acc_soft_reset), .acc_out(acc_out),
      .acc_out_valid(acc_out_valid), .dbg_read_req(dbg_read_req), .dbg_read_addr(dbg_read_addr),
      .dbg_read_grant(dbg_read_grant), .dbg_read_valid(dbg_read_valid), .dbg_read_data(dbg_read_data),
      .bram_read_addr(bram_read_addr), .bram_data(bram_data), .result(result),
      .result_valid(result_valid), .busy(busy), .timeout(timeout), .frame_count(frame_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic dbg_read(input logic [9:0] a, input bit exp_grant, input logic [9:0] acc_a);
      dbg_read_req  = 1'b1;
      dbg_read_addr = a;
      acc_read_addr = acc_a;
      #1;
      chk("dbg_grant", dbg_read_grant, exp_grant);
      chk("bram_addr", bram_read_addr, exp_grant ? a : acc_a);
      if (exp_grant) sb_q.push_back(mem[a]);
      @(negedge clock);
      dbg_read_req = 1'b0;
      chk("dbg_valid", dbg_read_valid, exp_grant);
      if (dbg_read_valid) begin
         if (sb_q.size() == 0) chk("dbg_unexpected_valid", 1, 0);
         else chk("dbg_data", dbg_read_data, sb_q.pop_front());
      end
   endtask

   task automatic run_frame(input vec_t v);
      bram_ready = 1'b1;
      acc_out    = v.cls;
      @(negedge clock);
      chk("arm_soft_reset", acc_soft_reset, 1);
      chk("arm_enable", acc_enable, 0);
      chk("arm_busy", busy, 1);
      @(negedge clock);
      chk("run_enable", acc_enable, 1);
      for (int k = 1; k < v.run_cyc; k++) @(negedge clock);
      chk("run_still_enabled", acc_enable, 1);
      acc_out_valid = (v.mode != 1);
      frame_abort   = (v.mode != 0);
      @(negedge clock);
      acc_out_valid = 1'b0;
      frame_abort   = 1'b0;
      chk("end_enable", acc_enable, 0);
      chk("end_result", result, v.exp_res);
      chk("end_result_valid", result_valid, v.exp_valid);
      chk("end_frame_count", frame_count, v.exp_cnt);
      if (v.mode == 0) begin
         chk("done_soft_reset", acc_soft_reset, 0);
         repeat (3) @(negedge clock);
         chk("done_waits_ready_low", busy | acc_soft_reset, 0);
         bram_ready = 1'b0;
         repeat (2) @(negedge clock);
         chk("idle_busy", busy, 0);
      end else begin
         chk("abort_soft_reset", acc_soft_reset, 1);
         bram_ready = 1'b0;
         @(negedge clock);
         chk("abort_pulse_once", acc_soft_reset | busy, 0);
      end
   endtask

   task automatic fast_frame(input logic [3:0] cls);
      bram_ready = 1'b1;
      acc_out    = cls;
      repeat (2) @(negedge clock);
      acc_out_valid = 1'b1;
      @(negedge clock);
      acc_out_valid = 1'b0;
      bram_ready    = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int n;
      vecs[0] = '{4'd7,  50, 0, 10'h005, 4'd7,  1'b1, 8'd1};
      vecs[1] = '{4'd9,  20, 1, 10'h000, 4'd7,  1'b0, 8'd1};
      vecs[2] = '{4'd3,  10, 2, 10'h3FF, 4'd7,  1'b0, 8'd1};
      vecs[3] = '{4'd0,   1, 0, 10'h100, 4'd0,  1'b1, 8'd2};
      vecs[4] = '{4'd15,  5, 0, 10'h0AA, 4'd15, 1'b1, 8'd3};
      vecs[5] = '{4'd2,  30, 2, 10'h2C1, 4'd15, 1'b0, 8'd3};
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);

      repeat (2) @(negedge clock);
      chk("rst_enable", acc_enable, 0);
      chk("rst_soft_reset", acc_soft_reset, 0);
      chk("rst_dbg_valid", dbg_read_valid, 0);
      chk("rst_dbg_data", dbg_read_data, 0);
      chk("rst_result", result, 4'hF);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_frame_count", frame_count, 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 6; i++) begin
         dbg_read(vecs[i].dbg_addr, 1'b1, 10'h000);
         run_frame(vecs[i]);
      end

      // Debug request while the accelerator owns the port.
      bram_ready = 1'b1;
      repeat (2) @(negedge clock);
      chk("arb_in_run", acc_enable, 1);
      dbg_read(10'h005, 1'b0, 10'h123);
      frame_abort = 1'b1;
      @(negedge clock);
      frame_abort = 1'b0;
      bram_ready  = 1'b0;
      chk("arb_abort_soft_reset", acc_soft_reset, 1);
      @(negedge clock);

      // Asynchronous reset in the middle of RUN.
      bram_ready = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("async_rst_enable", acc_enable, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_result", result, 4'hF);
      chk("async_rst_count", frame_count, 0);
      bram_ready = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 255; i++) fast_frame(4'(i));
      chk("wrap_255", frame_count, 8'd255);
      fast_frame(4'd6);
      chk("wrap_0", frame_count, 8'd0);
      chk("wrap_result", result, 4'd6);

      bram_ready = 1'b1;
      repeat (2) @(negedge clock);
`ifdef INFER_CTRL_WDT_EN
      n = 1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clock);
         if (!acc_enable) break;
         n++;
      end
      chk("wdt_run_cycles", n, 100);
      chk("wdt_timeout", timeout, 1);
      chk("wdt_result", result, 4'hF);
      chk("wdt_result_valid", result_valid, 0);
      chk("wdt_count", frame_count, 0);
      bram_ready = 1'b0;
      repeat (2) @(negedge clock);
      bram_ready = 1'b1;
      @(negedge clock);
      chk("wdt_arm_clears_timeout", timeout, 0);
      @(negedge clock);
`else
      n = 0;
      repeat (150) @(negedge clock);
      chk("nowdt_still_running", acc_enable, 1);
      chk("nowdt_timeout", timeout, 0);
`endif
      frame_abort = 1'b1;
      @(negedge clock);
      frame_abort = 1'b0;
      bram_ready  = 1'b0;
      @(negedge clock);
      chk("final_idle", busy | acc_enable, 0);
      chk("sb_drain", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/inference_ctrl.md
# inference_ctrl

Frame-level sequencer between the UART ifmap loader and the CNN accelerator core. It takes over the enable/abort handling at the top level and runs one inference per received frame. It also owns the single read port of the ifmap BRAM, sharing it between the accelerator and a debug readback requester. Final outputs are latched for the seven-segment display, and an optional watchdog guards against a hung accelerator.

## Interface
Parameters:
- ADDR_W, 10, ifmap BRAM address width
- DATA_W, 8, ifmap BRAM data width
- CLS_W, 4, classification result width
- RESULT_RST, 4'hF, result value at reset/timeout
- TMO_CYC, 1048575, watchdog limit in clock cycles (20-bit counter)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_abort  in  1  synchronous abort pulse (new frame start on rx line)
- bram_ready  in  1  level; ifmap BRAM holds a complete frame
- acc_read_en  in  1  accelerator read strobe
- acc_read_addr  in  ADDR_W  accelerator read address
- acc_data  out  DATA_W  BRAM data to accelerator (passthrough of bram_data)
- acc_enable  out  1  accelerator run enable (registered)
- acc_soft_reset  out  1  one-cycle clear pulse to accelerator
- acc_out  in  CLS_W  accelerator class result
- acc_out_valid  in  1  result strobe
- dbg_read_req  in  1  debug read request
- dbg_read_addr  in  ADDR_W  debug read address
- dbg_read_grant  out  1  combinational grant for this cycle
- dbg_read_valid  out  1  dbg_read_data valid (1 cycle after grant)
- dbg_read_data  out  DATA_W  registered BRAM data for debug
- bram_read_addr  out  ADDR_W  muxed BRAM read address
- bram_data  in  DATA_W  BRAM read data (1-cycle read latency)
- result  out  CLS_W  latched class, drives seg7 encoder
- result_valid  out  1  result belongs to the latest completed frame
- busy  out  1  FSM in ARM or RUN
- timeout  out  1  sticky watchdog flag
- frame_count  out  8  completed-frame counter, wraps 255->0

## Operation
- FSM states: IDLE, ARM, RUN, DONE, ABORT.
- IDLE: acc_enable=0. If bram_ready=1, go to ARM.
- ARM (1 cycle): acc_soft_reset=1, clear watchdog, clear timeout, clear result_valid. Go to RUN.
- RUN: acc_enable=1, watchdog increments.
  - acc_out_valid=1: result<=acc_out, result_valid<=1, frame_count++, go to DONE.
  - Watchdog reaches TMO_CYC: result<=RESULT_RST, timeout<=1, go to DONE.
  - If acc_out_valid coincides with the watchdog limit, the valid result wins.
- DONE: acc_enable=0. Wait for bram_ready=0, then go to IDLE. This prevents re-running a stale frame.
- ABORT (1 cycle): acc_soft_reset=1, acc_enable=0, result_valid<=0. Go to IDLE. result and frame_count hold.
- frame_abort=1 in any state forces ABORT next cycle. It has priority over every other transition, including acc_out_valid in the same cycle (that result is discarded).
- Arbitration:
  - In RUN the accelerator owns the port unconditionally: bram_read_addr=acc_read_addr, dbg_read_grant=0.
  - In all other states: dbg_read_grant=dbg_read_req and bram_read_addr=dbg_read_addr.
  - A granted read returns dbg_read_data with dbg_read_valid=1 exactly 1 cycle later.
- An ungranted debug request has no effect; the requester holds req until granted.

## Timing
- Reset values: state=IDLE, acc_enable=0, acc_soft_reset=0, dbg_read_valid=0, dbg_read_data=0, result=RESULT_RST, result_valid=0, busy=0, timeout=0, frame_count=0.
- bram_ready rising edge in IDLE: ARM on the next edge, acc_enable=1 on the edge after that. Latency is 2 cycles from sampled ready to enable.
- acc_out_valid sampled in RUN: result and result_valid are updated on the same edge as the transition to DONE.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronous).
- frame_count wraps modulo 256; timeout frames do not increment it.

## Configuration
- INFER_CTRL_WDT_EN defined: the watchdog counter and timeout path are present, as described above.
- INFER_CTRL_WDT_EN undefined: no counter is instantiated, timeout is tied to 0, and RUN exits only on acc_out_valid or frame_abort.

## Test plan
- Normal frame: bram_ready=1, acc_out=4'd7 with valid 50 cycles into RUN. Expect:
  - acc_enable high 2 cycles after ready;
  - result=7, result_valid=1, frame_count=1;
  - IDLE only after bram_ready drops.
- Abort mid-RUN: frame_abort pulse on RUN cycle 20. Expect:
  - ABORT with acc_soft_reset for 1 cycle, acc_enable=0;
  - result holds its prior value, result_valid=0, frame_count unchanged.
- Simultaneous abort and acc_out_valid(acc_out=3): expect ABORT, and result is not updated to 3.
- Arbitration: dbg_read_req at addr 0x05 in IDLE expects grant=1 and valid 1 cycle later with BRAM[5]. The same request during RUN expects grant=0 and bram_read_addr equal to acc_read_addr.
- Watchdog (WDT_EN, TMO_CYC=100 in bench): no acc_out_valid. Expect:
  - timeout=1 and result=4'hF after 100 RUN cycles;
  - frame_count unchanged;
  - timeout cleared in the next ARM.
- Wrap: 256 completed frames return frame_count to 0.
